// File: rtl/sort_n_floats_using_fsm.sv
// Bubble-sort FSM for N floating-point values, one compare per cycle via an external f_le port.
// Optional early exit on a swap-free pass: define SORT_FLOATS_EARLY_EXIT_EN.
`ifndef FLEN
`define FLEN 32
`endif

module sort_n_floats_using_fsm #(
  parameter int N          = 4,
  parameter bit DESCENDING = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  input  logic [0:N-1][`FLEN-1:0]    unsorted,
  output logic                       valid_out,
  output logic [0:N-1][`FLEN-1:0]    sorted,
  output logic                       err,
  output logic                       busy,
  output logic [`FLEN-1:0]           f_le_a,
  output logic [`FLEN-1:0]           f_le_b,
  input  logic                       f_le_res,
  input  logic                       f_le_err
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state, state_nxt;
  logic [0:N-1][`FLEN-1:0]   buf_q, buf_nxt;
  logic [CW-1:0]             pass_q, pass_nxt;
  logic [CW-1:0]             idx_q, idx_nxt;
  logic [CW-1:0]             idx_p1, last_idx;
  logic                      pass_end, last_cmp;
  logic                      swap, finish;
`ifdef SORT_FLOATS_EARLY_EXIT_EN
  logic                      swapped_q, swapped_nxt;
`endif

  assign idx_p1   = idx_q + CW'(1);
  assign last_idx = CW'(N - 2) - pass_q;
  assign pass_end = (idx_q == last_idx);
  assign last_cmp = pass_end && (pass_q == CW'(N - 2));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    buf_nxt   = buf_q;
    pass_nxt  = pass_q;
    idx_nxt   = idx_q;
    f_le_a    = '0;
    f_le_b    = '0;
    swap      = 1'b0;
    finish    = 1'b0;
`ifdef SORT_FLOATS_EARLY_EXIT_EN
    swapped_nxt = swapped_q;
`endif
    case (state)
      IDLE: begin
        if (valid_in) begin
          state_nxt = SORT;
          buf_nxt   = unsorted;
          pass_nxt  = '0;
          idx_nxt   = '0;
`ifdef SORT_FLOATS_EARLY_EXIT_EN
          swapped_nxt = 1'b0;
`endif
        end
      end
      SORT: begin
        // Descending order just asks the comparator the reversed question.
        if (DESCENDING) begin
          f_le_a = buf_q[idx_p1];
          f_le_b = buf_q[idx_q];
        end else begin
          f_le_a = buf_q[idx_q];
          f_le_b = buf_q[idx_p1];
        end
        swap = !f_le_res && !f_le_err;
        if (swap) begin
          buf_nxt[idx_q]  = buf_q[idx_p1];
          buf_nxt[idx_p1] = buf_q[idx_q];
        end
`ifdef SORT_FLOATS_EARLY_EXIT_EN
        swapped_nxt = swapped_q || swap;
        if (f_le_err || last_cmp) begin
          finish = 1'b1;
        end else if (pass_end && !swapped_q && !swap) begin
          finish = 1'b1;
        end
`else
        finish = f_le_err || last_cmp;
`endif
        if (finish) begin
          state_nxt = DONE;
        end else if (pass_end) begin
          pass_nxt = pass_q + CW'(1);
          idx_nxt  = '0;
`ifdef SORT_FLOATS_EARLY_EXIT_EN
          swapped_nxt = 1'b0;
`endif
        end else begin
          idx_nxt = idx_p1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Results are loaded on the final compare edge so valid_out and sorted line up in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q     <= '0;
      pass_q    <= '0;
      idx_q     <= '0;
      sorted    <= '0;
      err       <= 1'b0;
      valid_out <= 1'b0;
`ifdef SORT_FLOATS_EARLY_EXIT_EN
      swapped_q <= 1'b0;
`endif
    end else begin
      buf_q     <= buf_nxt;
      pass_q    <= pass_nxt;
      idx_q     <= idx_nxt;
      valid_out <= finish;
      if (finish) begin
        sorted <= buf_nxt;
        err    <= f_le_err;
      end
`ifdef SORT_FLOATS_EARLY_EXIT_EN
      swapped_q <= swapped_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_sort_n_floats_using_fsm.sv
// Bench for sort_n_floats_using_fsm: N=4 ascending and N=2 descending instances.
// Comparator and expected results come from an IEEE-754 single-precision model.
`ifndef FLEN
`define FLEN 32
`endif

module tb_sort_n_floats_using_fsm;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // DUT A: N=4 ascending
  logic               valid4, valid_out4, err4, busy4, res4, ferr4;
  logic [0:3][31:0]   unsorted4, sorted4;
  logic [31:0]        a4, b4;
  // DUT B: N=2 descending
  logic               valid2, valid_out2, err2, busy2, res2, ferr2;
  logic [0:1][31:0]   unsorted2, sorted2;
  logic [31:0]        a2, b2;

  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic [31:0] fkey(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic bit fle(input logic [31:0] x, input logic [31:0] y);
    if (x[30:0] == 31'd0 && y[30:0] == 31'd0) return 1'b1;
    return fkey(x) <= fkey(y);
  endfunction

  assign res4  = fle(a4, b4);
  assign ferr4 = is_nan(a4) | is_nan(b4);
  assign res2  = fle(a2, b2);
  assign ferr2 = is_nan(a2) | is_nan(b2);

  sort_n_floats_using_fsm #(.N(4), .DESCENDING(1'b0)) dut4 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid4), .unsorted(unsorted4),
    .valid_out(valid_out4), .sorted(sorted4), .err(err4), .busy(busy4),
    .f_le_a(a4), .f_le_b(b4), .f_le_res(res4), .f_le_err(ferr4)
  );

  sort_n_floats_using_fsm #(.N(2), .DESCENDING(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid2), .unsorted(unsorted2),
    .valid_out(valid_out2), .sorted(sorted2), .err(err2), .busy(busy2),
    .f_le_a(a2), .f_le_b(b2), .f_le_res(res2), .f_le_err(ferr2)
  );

  // Reference bubble sort: sorts in place, stops at the first NaN compare.
  function automatic void model(input logic [0:3][31:0] v, input int n, input bit desc,
                                output logic [0:3][31:0] r, output bit e, output int lat);
    logic [31:0] x, y, t;
    int cmps;
`ifdef SORT_FLOATS_EARLY_EXIT_EN
    bit sw;
`endif
    r = v;
    e = 1'b0;
    cmps = 0;
    lat = 0;
    for (int p = 0; p < n - 1; p++) begin
`ifdef SORT_FLOATS_EARLY_EXIT_EN
      sw = 1'b0;
`endif
      for (int i = 0; i < n - 1 - p; i++) begin
        x = desc ? r[i+1] : r[i];
        y = desc ? r[i] : r[i+1];
        cmps++;
        if (is_nan(x) || is_nan(y)) begin
          e = 1'b1;
          lat = cmps + 1;
          return;
        end
        if (!fle(x, y)) begin
          t = r[i];
          r[i] = r[i+1];
          r[i+1] = t;
`ifdef SORT_FLOATS_EARLY_EXIT_EN
          sw = 1'b1;
`endif
        end
      end
`ifdef SORT_FLOATS_EARLY_EXIT_EN
      if (!sw) begin
        lat = cmps + 1;
        return;
      end
`endif
    end
    lat = cmps + 1;
  endfunction

  // Job descriptors handed from the driver to the compare process.
  int               seq4 = 0, seen4 = 0, seq2 = 0, seen2 = 0;
  logic [0:3][31:0] d4_v, d4_lit;
  int               d4_lat;
  bit               d4_err;
  logic [0:1][31:0] d2_v, d2_lit;
  int               d2_lat;

  logic [127:0] exp4_q[$];
  bit           exp4_err_q[$];
  int           exp4_dl_q[$];
  logic [127:0] exp2_q[$];
  bit           exp2_err_q[$];
  int           exp2_dl_q[$];

  logic [0:3][31:0] m_r;
  bit               m_e;
  int               m_lat;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy4", 128'(busy4), 128'(0));
      chk("rst_valid_out4", 128'(valid_out4), 128'(0));
      chk("rst_err4", 128'(err4), 128'(0));
      chk("rst_sorted4", 128'(sorted4), 128'(0));
      chk("rst_busy2", 128'(busy2), 128'(0));
      chk("rst_sorted2", 128'(sorted2), 128'(0));
      exp4_q.delete(); exp4_err_q.delete(); exp4_dl_q.delete();
      exp2_q.delete(); exp2_err_q.delete(); exp2_dl_q.delete();
      seen4 = seq4;
      seen2 = seq2;
    end else begin
      if (seq4 != seen4) begin
        seen4 = seq4;
        model(d4_v, 4, 1'b0, m_r, m_e, m_lat);
        chk("model4_sorted", 128'(m_r), 128'(d4_lit));
        chk("model4_latency", 128'(m_lat), 128'(d4_lat));
        chk("model4_err", 128'(m_e), 128'(d4_err));
        exp4_q.push_back(128'(m_r));
        exp4_err_q.push_back(m_e);
        exp4_dl_q.push_back(cyc + m_lat - 1);
      end
      if (seq2 != seen2) begin
        seen2 = seq2;
        model({d2_v, 64'h0}, 2, 1'b1, m_r, m_e, m_lat);
        chk("model2_sorted", 128'(m_r[0:1]), 128'(d2_lit));
        chk("model2_latency", 128'(m_lat), 128'(d2_lat));
        exp2_q.push_back(128'(m_r[0:1]));
        exp2_err_q.push_back(m_e);
        exp2_dl_q.push_back(cyc + m_lat - 1);
      end

      chk("busy4", 128'(busy4), 128'(exp4_q.size() > 0));
      if (exp4_q.size() > 0 && cyc == exp4_dl_q[0]) begin
        chk("valid_out4", 128'(valid_out4), 128'(1));
        chk("sorted4", 128'(sorted4), exp4_q[0]);
        chk("err4", 128'(err4), 128'(exp4_err_q[0]));
        void'(exp4_q.pop_front());
        void'(exp4_err_q.pop_front());
        void'(exp4_dl_q.pop_front());
      end else begin
        chk("valid_out4_quiet", 128'(valid_out4), 128'(0));
      end
      if (exp4_q.size() == 0 && !valid_out4) begin
        chk("f_le_idle4", 128'({a4, b4}), 128'(0));
      end

      chk("busy2", 128'(busy2), 128'(exp2_q.size() > 0));
      if (exp2_q.size() > 0 && cyc == exp2_dl_q[0]) begin
        chk("valid_out2", 128'(valid_out2), 128'(1));
        chk("sorted2", 128'(sorted2), exp2_q[0]);
        chk("err2", 128'(err2), 128'(exp2_err_q[0]));
        void'(exp2_q.pop_front());
        void'(exp2_err_q.pop_front());
        void'(exp2_dl_q.pop_front());
      end else begin
        chk("valid_out2_quiet", 128'(valid_out2), 128'(0));
      end
    end
  end

  // extra: pulse valid_in at cycles 2, 4 and 7 with junk data; abort_at: reset in that cycle.
  task automatic job4(input logic [0:3][31:0] v, input logic [0:3][31:0] lit, input int lit_lat,
                      input bit lit_err, input bit extra, input int abort_at);
    @(negedge clk);
    unsorted4 = v;
    valid4    = 1'b1;
    d4_v      = v;
    d4_lit    = lit;
    d4_lat    = lit_lat;
    d4_err    = lit_err;
    @(posedge clk);
    #1;
    valid4 = 1'b0;
    seq4++;
    if (abort_at > 0) begin
      repeat (abort_at - 1) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
    end else begin
      for (int k = 1; k <= lit_lat + 2; k++) begin
        @(negedge clk);
        if (extra) begin
          valid4    = (k == 2 || k == 4 || k == 7);
          unsorted4 = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
      end
      valid4 = 1'b0;
    end
  endtask

  task automatic job2(input logic [0:1][31:0] v, input logic [0:1][31:0] lit, input int lit_lat);
    @(negedge clk);
    unsorted2 = v;
    valid2    = 1'b1;
    d2_v      = v;
    d2_lit    = lit;
    d2_lat    = lit_lat;
    @(posedge clk);
    #1;
    valid2 = 1'b0;
    seq2++;
    repeat (lit_lat + 2) @(negedge clk);
  endtask

  localparam logic [31:0] F1  = 32'h3F80_0000;  // 1.0
  localparam logic [31:0] F2  = 32'h4000_0000;  // 2.0
  localparam logic [31:0] F3  = 32'h4040_0000;  // 3.0
  localparam logic [31:0] F4  = 32'h4080_0000;  // 4.0
  localparam logic [31:0] FM1 = 32'hBF80_0000;  // -1.0
  localparam logic [31:0] FH  = 32'h3F00_0000;  // 0.5
  localparam logic [31:0] FN  = 32'h7FC0_0000;  // quiet NaN
  localparam logic [31:0] F15 = 32'h3FC0_0000;  // 1.5
  localparam logic [31:0] FM3 = 32'hC040_0000;  // -3.0

  int t2_lat;

  initial begin
    rst_n     = 1'b0;
    valid4    = 1'b0;
    valid2    = 1'b0;
    unsorted4 = '0;
    unsorted2 = '0;
`ifdef SORT_FLOATS_EARLY_EXIT_EN
    t2_lat = 4;
`else
    t2_lat = 7;
`endif
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    job4({F3, F1, F4, F2}, {F1, F2, F3, F4}, 7, 1'b0, 1'b0, 0);
    job4({F1, F2, F3, F4}, {F1, F2, F3, F4}, t2_lat, 1'b0, 1'b0, 0);
    job4({F2, FM1, FN, FH}, {FM1, F2, FN, FH}, 3, 1'b1, 1'b0, 0);
    job4({F2, F2, FM1, F2}, {FM1, F2, F2, F2}, 7, 1'b0, 1'b1, 0);
    job4({F4, F3, F2, F1}, {F1, F2, F3, F4}, 7, 1'b0, 1'b0, 3);
    job4({F4, F3, F2, F1}, {F1, F2, F3, F4}, 7, 1'b0, 1'b0, 0);
    job2({F15, FM3}, {F15, FM3}, 2);
    job2({FM3, F15}, {F15, FM3}, 2);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
